object_trajectory: RTL



---
 rtl/obj_motion_pkg.sv | 27 ++
 rtl/tick_prescaler.sv | 36 +++
 rtl/object_trajectory.sv | 125 ++++++++++++
 3 files changed

// File: rtl/obj_motion_pkg.sv
// Shared types and helpers for the sprite motion blocks: trajectory state
// encoding, default playfield size and a clamping signed adder.
package obj_motion_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        EXIT = 2'd2
    } traj_state_t;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;

    // a + b clamped to the range of a w-bit two's complement number
    function automatic int sat_add(input int a, input int b, input int w);
        int hi;
        int lo;
        int s;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        s  = a + b;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every max(period,1) enabled cycles.
// The count holds while disabled, so a pause resumes mid-interval.
module tick_prescaler #(
    parameter int TICK_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clear,
    input  logic [TICK_W-1:0] period,
    output logic              tick
);

    logic [TICK_W-1:0] cnt_q, cnt_d;
    logic [TICK_W-1:0] last;

    assign last = (period == '0) ? '0 : period - TICK_W'(1);
    assign tick = enable && (cnt_q == last);

    // a live shrink of period below the current count wraps without a tick
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q >= last) cnt_d = '0;
            else               cnt_d = cnt_q + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/object_trajectory.sv
// Ballistic sprite mover: launch loads position/velocity, each tick adds the
// velocity (gravity on vy), clamps at the ceiling and pulses done on exit.
module object_trajectory
    import obj_motion_pkg::*;
#(
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int V_W      = 8,
    parameter int TICK_W   = 32,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int GRAVITY  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              launch,
    input  logic [X_W-1:0]    init_x,
    input  logic [Y_W-1:0]    init_y,
    input  logic [V_W-1:0]    init_vx,
    input  logic [V_W-1:0]    init_vy,
    input  logic [TICK_W-1:0] tick_period,
    input  logic              freeze,
    output logic [X_W-1:0]    posx,
    output logic [Y_W-1:0]    posy,
    output logic              active,
    output logic              busy,
    output logic              done
);

    localparam int XS = X_W + 2;
    localparam int YS = Y_W + 2;

    traj_state_t state_q, state_d;

    logic [X_W-1:0]        posx_q, posx_d;
    logic [Y_W-1:0]        posy_q, posy_d;
    logic signed [V_W-1:0] vx_q, vx_d;
    logic signed [V_W-1:0] vy_q, vy_d;

    logic                  launch_acc;
    logic                  tick;
    logic signed [XS-1:0]  nx;
    logic signed [YS-1:0]  ny;
    logic                  exit_hit;
    logic signed [V_W-1:0] vy_next;

    assign launch_acc = launch && (state_q == IDLE);

    tick_prescaler #(.TICK_W(TICK_W)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable ((state_q == FLY) && !freeze),
        .clear  (launch_acc),
        .period (tick_period),
        .tick   (tick)
    );

    // Two extra bits hold both the sign and the overflow past the playfield
    assign nx       = $signed({2'b00, posx_q}) + XS'(vx_q);
    assign ny       = $signed({2'b00, posy_q}) + YS'(vy_q);
    assign exit_hit = nx[XS-1] || (nx >= XS'(SCREEN_W)) || (ny >= YS'(SCREEN_H));
    assign vy_next  = V_W'(sat_add(int'(vy_q), GRAVITY, V_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch_acc) state_d = FLY;
            FLY:     if (tick && exit_hit) state_d = EXIT;
            EXIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        active = (state_q == FLY);
        busy   = (state_q != IDLE);
        done   = (state_q == EXIT);
    end

    always_comb begin
        posx_d = posx_q;
        posy_d = posy_q;
        vx_d   = vx_q;
        vy_d   = vy_q;
        if (launch_acc) begin
            posx_d = init_x;
            posy_d = init_y;
            vx_d   = init_vx;
            vy_d   = init_vy;
        end else if (tick && !exit_hit) begin
            posx_d = nx[X_W-1:0];
            // ceiling hit kills upward speed and skips gravity for this tick
            if (ny[YS-1]) begin
                posy_d = '0;
                vy_d   = '0;
            end else begin
                posy_d = ny[Y_W-1:0];
                vy_d   = vy_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            posx_q <= '0;
            posy_q <= '0;
            vx_q   <= '0;
            vy_q   <= '0;
        end else begin
            posx_q <= posx_d;
            posy_q <= posy_d;
            vx_q   <= vx_d;
            vy_q   <= vy_d;
        end
    end

    assign posx = posx_q;
    assign posy = posy_q;

endmodule
